// File: rtl/vcm_focus_pkg.sv
// Shared types and constants for the contrast-detect autofocus controller.
package vcm_focus_pkg;

    typedef enum logic [2:0] {IDLE, WRITE, SETTLE, MEAS, PARK, DONE} state_t;
    typedef enum logic {COARSE, FINE} pass_t;

    localparam logic [7:0] LUMA_R = 8'd77;
    localparam logic [7:0] LUMA_G = 8'd150;
    localparam logic [7:0] LUMA_B = 8'd29;

    localparam logic [1:0] VCM_PAD_HI = 2'b00;
    localparam logic [3:0] VCM_PAD_LO = 4'b1111;

    function automatic logic [15:0] vcm_frame(input logic [9:0] step);
        return {VCM_PAD_HI, step, VCM_PAD_LO};
    endfunction

endpackage

// File: rtl/vcm_focus_metric.sv
// Per-frame focus metric: luma, |Y(n)-Y(n-2)| edge detect and a saturating
// count of ROI pixels whose edge exceeds the threshold, latched at each frame start.
module vcm_focus_metric
    import vcm_focus_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int SUM_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    input  logic             vs,
    input  logic             activ,
    input  logic [PIX_W-1:0] th,
    output logic [SUM_W-1:0] focus_sum,
    output logic             frame_tick
);

    localparam int YW = PIX_W + 8;
    localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

    logic [YW-1:0]    y_full;
    logic [PIX_W-1:0] y_cur, y_h1, y_h2, dy;
    logic             activ_d1, activ_d2, vs_q, vs_rise;
    logic [SUM_W-1:0] acc;

    assign y_full  = YW'(r) * YW'(LUMA_R) + YW'(g) * YW'(LUMA_G) + YW'(b) * YW'(LUMA_B);
    assign vs_rise = vs & ~vs_q;

    // frame_tick trails the VS edge by one cycle so consumers see the new focus_sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_cur      <= '0;
            y_h1       <= '0;
            y_h2       <= '0;
            dy         <= '0;
            activ_d1   <= 1'b0;
            activ_d2   <= 1'b0;
            vs_q       <= 1'b0;
            acc        <= '0;
            focus_sum  <= '0;
            frame_tick <= 1'b0;
        end else begin
            y_cur      <= y_full[YW-1:8];
            y_h1       <= y_cur;
            y_h2       <= y_h1;
            activ_d1   <= activ;
            dy         <= (y_cur > y_h2) ? (y_cur - y_h2) : (y_h2 - y_cur);
            activ_d2   <= activ_d1;
            vs_q       <= vs;
            frame_tick <= vs_rise;
            if (vs_rise) begin
                focus_sum <= acc;
                acc       <= '0;
            end else if (activ_d2 && (dy > th) && (acc != SUM_MAX)) begin
                acc <= acc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vcm_focus_sweep.sv
// Autofocus controller: coarse then fine VCM lens sweep driven by the per-frame
// focus metric, with a req/ack handshake to the VCM writer.
module vcm_focus_sweep
    import vcm_focus_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int SUM_W      = 24,
    parameter int STEP_MIN   = 0,
    parameter int STEP_MAX   = 1020,
    parameter int COARSE_INC = 32,
    parameter int FINE_INC   = 4,
    parameter int SETTLE_FR  = 1
) (
    input  logic             VIDEO_CLK,
    input  logic             RESET,
    input  logic [PIX_W-1:0] iR,
    input  logic [PIX_W-1:0] iG,
    input  logic [PIX_W-1:0] iB,
    input  logic             VS,
    input  logic             ACTIV,
    input  logic             AUTO_FOC,
    input  logic [PIX_W-1:0] iTH,
    output logic             VCM_REQ,
    input  logic             VCM_ACK,
    output logic [15:0]      VCM_DATA,
    output logic [9:0]       STEP,
    output logic [9:0]       PEAK_STEP,
    output logic [SUM_W-1:0] FOCUS_SUM,
    output logic             VCM_END
);

    localparam logic [9:0]  MIN10  = 10'(STEP_MIN);
    localparam logic [10:0] MIN11  = 11'(STEP_MIN);
    localparam logic [10:0] MAX11  = 11'(STEP_MAX);
    localparam logic [10:0] INC_C  = 11'(COARSE_INC);
    localparam logic [10:0] INC_F  = 11'(FINE_INC);
    localparam logic [10:0] BACK11 = 11'(COARSE_INC - FINE_INC);
    localparam logic [7:0]  SET8   = 8'(SETTLE_FR);

    state_t           state, state_n;
    pass_t            pass, pass_n;
    logic [9:0]       step_n, peak_step_n, fine_end, fine_end_n, best_step, fine_start, fine_stop;
    logic [SUM_W-1:0] peak, peak_n;
    logic [7:0]       settle_cnt, settle_n;
    logic             req_n, end_n, better, frame_tick;
    logic [10:0]      best11, step_up_c, step_up_f;

    vcm_focus_metric #(.PIX_W(PIX_W), .SUM_W(SUM_W)) u_metric (
        .clk        (VIDEO_CLK),
        .rst        (RESET),
        .r          (iR),
        .g          (iG),
        .b          (iB),
        .vs         (VS),
        .activ      (ACTIV),
        .th         (iTH),
        .focus_sum  (FOCUS_SUM),
        .frame_tick (frame_tick)
    );

    // Ties keep the earlier step, so only a strictly larger sum wins
    assign better     = FOCUS_SUM > peak;
    assign best_step  = better ? STEP : PEAK_STEP;
    assign best11     = {1'b0, best_step};
    assign step_up_c  = {1'b0, STEP} + INC_C;
    assign step_up_f  = {1'b0, STEP} + INC_F;
    assign fine_start = (best11 < MIN11 + BACK11) ? MIN10 : 10'(best11 - BACK11);
    assign fine_stop  = (best11 + BACK11 > MAX11) ? MAX11[9:0] : 10'(best11 + BACK11);
    assign VCM_DATA   = vcm_frame(STEP);

    always_comb begin
        state_n     = state;
        pass_n      = pass;
        step_n      = STEP;
        peak_n      = peak;
        peak_step_n = PEAK_STEP;
        fine_end_n  = fine_end;
        settle_n    = settle_cnt;
        req_n       = VCM_REQ;
        end_n       = VCM_END;
        if (!AUTO_FOC) begin
            state_n = IDLE;
            req_n   = 1'b0;
            end_n   = 1'b0;
            peak_n  = '0;
        end else begin
            unique case (state)
                // PEAK_STEP restarts too, so a featureless scene parks at STEP_MIN
                IDLE: begin
                    step_n      = MIN10;
                    peak_step_n = MIN10;
                    peak_n      = '0;
                    pass_n      = COARSE;
                    req_n       = 1'b1;
                    state_n     = WRITE;
                end
                WRITE: begin
                    if (VCM_ACK) begin
                        req_n    = 1'b0;
                        settle_n = SET8;
                        state_n  = (SETTLE_FR == 0) ? MEAS : SETTLE;
                    end
                end
                SETTLE: begin
                    if (frame_tick) begin
                        if (settle_cnt <= 8'd1) begin
                            settle_n = '0;
                            state_n  = MEAS;
                        end else begin
                            settle_n = settle_cnt - 8'd1;
                        end
                    end
                end
                MEAS: begin
                    if (frame_tick) begin
                        if (better) begin
                            peak_n      = FOCUS_SUM;
                            peak_step_n = STEP;
                        end
                        req_n   = 1'b1;
                        state_n = WRITE;
                        if (pass == COARSE) begin
                            if (step_up_c > MAX11) begin
                                pass_n     = FINE;
                                step_n     = fine_start;
                                fine_end_n = fine_stop;
                            end else begin
                                step_n = step_up_c[9:0];
                            end
                        end else if (step_up_f > {1'b0, fine_end}) begin
                            step_n  = best_step;
                            state_n = PARK;
                        end else begin
                            step_n = step_up_f[9:0];
                        end
                    end
                end
                PARK: begin
                    if (VCM_ACK) begin
                        req_n   = 1'b0;
                        end_n   = 1'b1;
                        state_n = DONE;
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge VIDEO_CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            pass       <= COARSE;
            STEP       <= MIN10;
            PEAK_STEP  <= MIN10;
            peak       <= '0;
            fine_end   <= MIN10;
            settle_cnt <= '0;
            VCM_REQ    <= 1'b0;
            VCM_END    <= 1'b0;
        end else begin
            state      <= state_n;
            pass       <= pass_n;
            STEP       <= step_n;
            PEAK_STEP  <= peak_step_n;
            peak       <= peak_n;
            fine_end   <= fine_end_n;
            settle_cnt <= settle_n;
            VCM_REQ    <= req_n;
            VCM_END    <= end_n;
        end
    end

endmodule
